// File: rtl/peri_regbank_model_pkg.sv
// Shared definitions for the peripheral register bank model: FSM state
// encoding, the idle value driven on rdat, and the jitter LFSR constants.
package peri_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] RD_DEFAULT = 32'hffff_ffff;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7, 5, 4, 3 feed the XOR
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // One step of the Fibonacci LFSR: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/peri_regbank_model_if.sv
// Peripheral bus between CPU (master) and register bank (slave).
//   regw/regr : write/read request, held by the master until ack
//   adr       : byte address
//   wdata     : write data
//   wstrb     : write byte enables
//   ack       : one-cycle completion pulse
//   err       : decode error, valid with ack
//   rdat      : read data, valid with ack on reads
//   busy      : slave has a transaction in flight
interface peri_regbank_model_if;
    logic        regw;
    logic        regr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic        busy;

    modport master (
        output regw, regr, adr, wdata, wstrb,
        input  ack, err, rdat, busy
    );

    modport slave (
        input  regw, regr, adr, wdata, wstrb,
        output ack, err, rdat, busy
    );
endinterface

// File: rtl/peri_regbank_model_lat_lfsr.sv
// 8-bit LFSR supplying the per-request latency jitter.
//   clk     : clock, rising edge
//   rstz    : asynchronous active-low reset, loads LFSR_SEED
//   step_i  : advance the LFSR one step
//   lfsr_o  : low two state bits (0..3 extra cycles)
module peri_lat_lfsr
    import peri_model_pkg::*;
(
    input  logic       clk,
    input  logic       rstz,
    input  logic       step_i,
    output logic [1:0] lfsr_o
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q[1:0];

endmodule

// File: rtl/peri_regbank_model.sv
// Memory-mapped peripheral register bank model with programmable ack
// latency and optional LFSR jitter. Register 0 is a read-only ID; registers
// 1..NREG-1 are byte-strobed 32-bit storage. Out-of-range or misaligned
// accesses complete with err=1.
//   clk   : clock, rising edge
//   rstz  : asynchronous active-low reset
//   bus   : peripheral bus, slave side (regw/regr/adr/wdata/wstrb in,
//           ack/err/rdat/busy out)
module peri_regbank_model
    import peri_model_pkg::*;
#(
    parameter int          NREG     = 8,
    parameter logic [31:0] BASE     = 32'h4000_0000,
    parameter int          LAT      = 2,
    parameter int          JITTER   = 0,
    parameter logic [31:0] ID_VALUE = 32'h1234_5678,
    parameter logic [31:0] RST_VAL  = 32'hffff_ffff
) (
    input logic                  clk,
    input logic                  rstz,
    peri_regbank_model_if.slave  bus
);

    localparam int          IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [31:0] SPAN  = 32'(4 * NREG);

    if (LAT < 1) begin : g_lat_chk
        $error("peri_regbank_model: LAT must be >= 1");
    end
    if (NREG < 2) begin : g_nreg_chk
        $error("peri_regbank_model: NREG must be >= 2");
    end
    if ((BASE % SPAN) != 0) begin : g_base_chk
        $error("peri_regbank_model: BASE must be 4*NREG aligned");
    end

    state_t      state_q;
    logic        wr_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] cnt_q;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] rdat_q;
    logic [31:0] regs_q [NREG];

    logic             req;
    logic             accept;
    logic [1:0]       jit;
    logic [15:0]      cnt_d;
    logic [31:0]      off;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             done;
    logic             commit;
    logic [31:0]      rdat_d;

    assign req    = bus.regw | bus.regr;
    assign accept = (state_q == IDLE) && req;

    // The LFSR advances on every acceptance regardless of JITTER, so the
    // jitter sequence does not depend on the mode.
    peri_lat_lfsr u_lfsr (
        .clk    (clk),
        .rstz   (rstz),
        .step_i (accept),
        .lfsr_o (jit)
    );

    assign cnt_d = 16'(LAT - 1) + ((JITTER != 0) ? {14'b0, jit} : 16'b0);

    // Decode works on the captured address; subtracting first keeps the
    // upper-bound compare free of BASE+SPAN overflow.
    assign off  = adr_q - BASE;
    assign hit  = (adr_q[1:0] == 2'b00) && (adr_q >= BASE) && (off < SPAN);
    assign idx  = off[IDX_W+1:2];
    assign done = (state_q == WAIT) && (cnt_q == 16'd0);
    assign commit = done && wr_q && hit && (idx != '0);

    always_comb begin
        rdat_d = RD_DEFAULT;
        if (!wr_q && hit) begin
            rdat_d = (idx == '0) ? ID_VALUE : regs_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdat_q  <= RD_DEFAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= bus.regw;
                        adr_q   <= bus.adr;
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        cnt_q   <= cnt_d;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 16'd0) begin
                        ack_q   <= 1'b1;
                        err_q   <= ~hit;
                        rdat_q  <= rdat_d;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdat_q  <= RD_DEFAULT;
                    state_q <= HOLD;
                end
                HOLD: begin
                    // A request still held after its ack must not be served twice.
                    if (!req) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register 0 holds no storage of interest; its read value is ID_VALUE.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    regs_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.rdat = rdat_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_peri_regbank_model.sv
// Directed bench for peri_regbank_model: a fixed-latency instance (LAT=2)
// and a jittered instance (LAT=3, JITTER=1) share clock and reset.
module tb_peri_regbank_model;

    logic clk;
    logic rstz;

    peri_regbank_model_if b1 ();
    peri_regbank_model_if b2 ();

    peri_regbank_model #(.LAT(2), .JITTER(0)) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (b1)
    );

    peri_regbank_model #(.LAT(3), .JITTER(1)) dut_j (
        .clk  (clk),
        .rstz (rstz),
        .bus  (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Full transaction on the LAT=2 instance. Request is driven #1 after a
    // posedge; the next posedge accepts it. lat counts posedges from
    // acceptance up to the one that raised ack.
    task automatic xact(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int lat, output logic e, output logic [31:0] rd);
        logic found;
        b1.regw = w; b1.regr = r; b1.adr = a; b1.wdata = wd; b1.wstrb = st;
        @(posedge clk); #1;
        chk("busy_after_accept", {31'b0, b1.busy}, 32'd1);
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge clk); #1;
            lat = k;
            if (b1.ack) found = 1'b1;
        end
        chk("ack_seen", {31'b0, found}, 32'd1);
        e  = b1.err;
        rd = b1.rdat;
        b1.regw = 1'b0; b1.regr = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'b0, b1.ack}, 32'd0);
        @(posedge clk); #1;
        chk("busy_idle", {31'b0, b1.busy}, 32'd0);
    endtask

    int          lat;
    logic        e;
    logic [31:0] rd;
    int          nack;
    int          exp_lat;
    logic [7:0]  m;
    logic        found;

    initial begin
        rstz = 1'b0;
        b1.regw = 0; b1.regr = 0; b1.adr = '0; b1.wdata = '0; b1.wstrb = '0;
        b2.regw = 0; b2.regr = 0; b2.adr = '0; b2.wdata = '0; b2.wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",  {31'b0, b1.ack},  32'd0);
        chk("rst_err",  {31'b0, b1.err},  32'd0);
        chk("rst_busy", {31'b0, b1.busy}, 32'd0);
        chk("rst_rdat", b1.rdat, 32'hffff_ffff);
        rstz = 1'b1;
        @(posedge clk); #1;

        // 1. ID read, latency 2
        xact(0, 1, 32'h4000_0000, 0, 4'h0, lat, e, rd);
        chk("id_lat", 32'(lat), 32'd2);
        chk("id_err", {31'b0, e}, 32'd0);
        chk("id_rdat", rd, 32'h1234_5678);

        // 2. Write/readback with byte strobes
        xact(1, 0, 32'h4000_0008, 32'hDEAD_BEEF, 4'hF, lat, e, rd);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_err", {31'b0, e}, 32'd0);
        chk("wr_rdat_idle", rd, 32'hffff_ffff);
        xact(0, 1, 32'h4000_0008, 0, 4'h0, lat, e, rd);
        chk("rb_full", rd, 32'hDEAD_BEEF);
        xact(1, 0, 32'h4000_0008, 32'h0000_1234, 4'h3, lat, e, rd);
        xact(0, 1, 32'h4000_0008, 0, 4'h0, lat, e, rd);
        chk("rb_strb3", rd, 32'hDEAD_1234);
        xact(1, 0, 32'h4000_0008, 32'h5555_5555, 4'h0, lat, e, rd);
        chk("wstrb0_err", {31'b0, e}, 32'd0);
        xact(0, 1, 32'h4000_0008, 0, 4'h0, lat, e, rd);
        chk("rb_wstrb0", rd, 32'hDEAD_1234);

        // 3. Decode errors and ID write
        xact(0, 1, 32'h4000_0020, 0, 4'h0, lat, e, rd);
        chk("oor_err", {31'b0, e}, 32'd1);
        chk("oor_rdat", rd, 32'hffff_ffff);
        xact(0, 1, 32'h4000_0006, 0, 4'h0, lat, e, rd);
        chk("mis_err", {31'b0, e}, 32'd1);
        chk("mis_rdat", rd, 32'hffff_ffff);
        xact(0, 1, 32'h3FFF_FFFC, 0, 4'h0, lat, e, rd);
        chk("below_err", {31'b0, e}, 32'd1);
        xact(1, 0, 32'h4000_000A, 32'h0, 4'hF, lat, e, rd);
        chk("mis_wr_err", {31'b0, e}, 32'd1);
        xact(0, 1, 32'h4000_0008, 0, 4'h0, lat, e, rd);
        chk("mis_wr_nochg", rd, 32'hDEAD_1234);
        xact(1, 0, 32'h4000_0000, 32'h0, 4'hF, lat, e, rd);
        chk("idwr_err", {31'b0, e}, 32'd0);
        xact(0, 1, 32'h4000_0000, 0, 4'h0, lat, e, rd);
        chk("id_kept", rd, 32'h1234_5678);

        // 4. Held request served once; regw&regr is a write; back-to-back
        b1.regw = 1; b1.regr = 0; b1.adr = 32'h4000_000C; b1.wdata = 32'h1111_2222; b1.wstrb = 4'hF;
        @(posedge clk); #1;
        nack = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (b1.ack) nack++;
        end
        b1.regw = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("held_one_ack", 32'(nack), 32'd1);
        chk("held_busy_idle", {31'b0, b1.busy}, 32'd0);
        xact(0, 1, 32'h4000_000C, 0, 4'h0, lat, e, rd);
        chk("held_commit", rd, 32'h1111_2222);
        xact(1, 1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, lat, e, rd);
        chk("wr_rd_both_rdat", rd, 32'hffff_ffff);
        xact(0, 1, 32'h4000_0010, 0, 4'h0, lat, e, rd);
        chk("wr_rd_both_commit", rd, 32'hCAFE_F00D);
        chk("b2b_lat", 32'(lat), 32'd2);

        // 5. Reset during WAIT aborts a write
        b1.regw = 1; b1.adr = 32'h4000_000C; b1.wdata = 32'h0; b1.wstrb = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstz = 1'b0;
        #1;
        chk("abort_ack", {31'b0, b1.ack}, 32'd0);
        chk("abort_busy", {31'b0, b1.busy}, 32'd0);
        chk("abort_rdat", b1.rdat, 32'hffff_ffff);
        b1.regw = 0;
        nack = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (b1.ack) nack++;
        end
        rstz = 1'b1;
        @(posedge clk); #1;
        if (b1.ack) nack++;
        chk("abort_no_ack", 32'(nack), 32'd0);
        for (int r = 1; r < 8; r++) begin
            xact(0, 1, 32'h4000_0000 + 32'(4 * r), 0, 4'h0, lat, e, rd);
            chk($sformatf("rst_reg%0d", r), rd, 32'hffff_ffff);
        end

        // 6. Jittered latency on the LAT=3 instance
        m = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            exp_lat = 3 + int'(m[1:0]);
            m = model_lfsr(m);
            b2.regr = 1; b2.adr = 32'h4000_0000 + 32'(4 * (i % 8));
            @(posedge clk); #1;
            found = 1'b0;
            lat = 0;
            for (int k = 1; k <= 20 && !found; k++) begin
                @(posedge clk); #1;
                lat = k;
                if (b2.ack) found = 1'b1;
            end
            chk($sformatf("jit_lat%0d", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("jit_rdat%0d", i), b2.rdat,
                ((i % 8) == 0) ? 32'h1234_5678 : 32'hffff_ffff);
            b2.regr = 0;
            repeat (2) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
